// File: rtl/calc_seq_ctrl.sv
// Keypad-driven 4-bit calculator sequencer: conditions buttons, steps an operand-entry FSM, drives an external ALU.
// Optional debounce filter enabled by CALC_DEBOUNCE_EN; without it a press yields a pulse 3 cycles after the raw rise.
module calc_seq_ctrl #(
  parameter int DEB_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_enter,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_op,
  output logic       alu_start,
  input  logic       alu_done,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  output logic [6:0] seg,
  output logic       ovf,
  output logic       err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTER_A = 3'd1,
    S_ENTER_B = 3'd2,
    S_EXEC    = 3'd3,
    S_WAIT    = 3'd4,
    S_SHOW    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_E    = 7'b1111001;

  // Button bit order: {mode, enter, inc, dec}
  logic [3:0] raw;
  logic [3:0] sync1_q, sync2_q, lvl_q, pulse_q;
  logic [3:0] level;

  assign raw = {btn_mode, btn_enter, btn_inc, btn_dec};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      lvl_q   <= level;
      pulse_q <= level & ~lvl_q;
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] deb_cnt_q [4];
  logic [3:0]    filt_q;

  // A mismatch must persist DEB_CYCLES consecutive cycles; any return to the filtered level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          deb_cnt_q[i] <= '0;
          filt_q[i]    <= sync2_q[i];
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  logic p_mode, p_enter, p_inc, p_dec;
  assign {p_mode, p_enter, p_inc, p_dec} = pulse_q;

  state_t        state_q, state_d;
  logic [3:0]    edit_q, edit_d;
  logic [3:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic          op_q, op_d, ovf_q, ovf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [6:0]    seg_q, seg_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      edit_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= '0;
      seg_q   <= SEG_DASH;
    end else begin
      state_q <= state_d;
      edit_q  <= edit_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      seg_q   <= seg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (p_enter) begin
          state_d = S_ENTER_A;
          edit_d  = '0;
        end
      end
      S_ENTER_A, S_ENTER_B: begin
        if (p_mode) op_d = ~op_q;
        if (p_enter) begin
          if (state_q == S_ENTER_A) begin
            a_d     = edit_q;
            edit_d  = '0;
            state_d = S_ENTER_B;
          end else begin
            b_d     = edit_q;
            state_d = S_EXEC;
          end
        end else if (p_inc && !p_dec) begin
          edit_d = edit_q + 4'd1;
        end else if (p_dec && !p_inc) begin
          edit_d = edit_q - 4'd1;
        end
      end
      S_EXEC: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion wins over timeout when both land in the same cycle.
        if (alu_done) begin
          res_d   = alu_result;
          ovf_d   = alu_carry;
          state_d = S_SHOW;
        end else if (tmo_q == TMO_MAX) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (p_enter) begin
          a_d     = res_q;
          edit_d  = res_q;
          state_d = S_ENTER_A;
        end
      end
      S_ERR: begin
        if (p_enter) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;
      4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;
      default: hex7 = 7'b1110001;
    endcase
  endfunction

  always_comb begin
    seg_d = SEG_DASH;
    case (state_q)
      S_ENTER_A, S_ENTER_B: seg_d = hex7(edit_q);
      S_EXEC, S_WAIT:       seg_d = hex7(b_q);
      S_SHOW:               seg_d = hex7(res_q);
      S_ERR:                seg_d = SEG_E;
      default:              seg_d = SEG_DASH;
    endcase
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign alu_start = (state_q == S_EXEC);
  assign seg       = seg_q;
  assign ovf       = ovf_q;
  assign err       = (state_q == S_ERR);
  assign state     = state_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: table of button presses with expected outputs, plus hand-written ALU/timeout/reset sequences.
module tb_calc_seq_ctrl;

  localparam int T    = 20;
  localparam int HOLD = 12;

  localparam logic [3:0] B_MODE  = 4'b1000;
  localparam logic [3:0] B_ENTER = 4'b0100;
  localparam logic [3:0] B_INC   = 4'b0010;
  localparam logic [3:0] B_DEC   = 4'b0001;

  logic       clk, rst;
  logic       btn_mode, btn_enter, btn_inc, btn_dec;
  logic [3:0] alu_a, alu_b;
  logic       alu_op, alu_start, alu_done, alu_carry;
  logic [3:0] alu_result;
  logic [6:0] seg;
  logic       ovf, err;
  logic [2:0] state;

  int nvec = 0;
  int nerr = 0;

  logic [6:0] hex_lut [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                               7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  calc_seq_ctrl #(.DEB_CYCLES(4), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_enter(btn_enter), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_carry(alu_carry),
    .seg(seg), .ovf(ovf), .err(err), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] btn;
    logic [2:0] st;
    logic [3:0] a;
    logic [3:0] b;
    logic       op;
    logic [6:0] sg;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] m);
    {btn_mode, btn_enter, btn_inc, btn_dec} = m;
    repeat (HOLD) @(negedge clk);
    {btn_mode, btn_enter, btn_inc, btn_dec} = 4'b0000;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      press(tbl[i].btn);
      chk($sformatf("v%0d.state", i), 8'(state), 8'(tbl[i].st));
      chk($sformatf("v%0d.alu_a", i), 8'(alu_a), 8'(tbl[i].a));
      chk($sformatf("v%0d.alu_b", i), 8'(alu_b), 8'(tbl[i].b));
      chk($sformatf("v%0d.alu_op", i), 8'(alu_op), 8'(tbl[i].op));
      chk($sformatf("v%0d.seg", i), 8'(seg), 8'(tbl[i].sg));
    end
  endtask

  task automatic wait_state(input logic [2:0] s, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (state == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [3:0] r, input logic c,
                        input logic [3:0] ea, input logic [3:0] eb, input logic eop);
    bit seen;
    seen = 1'b0;
    btn_enter = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (alu_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk("start_seen", 8'(seen), 8'd1);
    chk("exec.state", 8'(state), 8'd3);
    chk("exec.alu_a", 8'(alu_a), 8'(ea));
    chk("exec.alu_b", 8'(alu_b), 8'(eb));
    chk("exec.alu_op", 8'(alu_op), 8'(eop));
    @(negedge clk);
    chk("start_one_cycle", 8'(alu_start), 8'd0);
    chk("wait.state", 8'(state), 8'd4);
    @(negedge clk);
    alu_done = 1'b1; alu_result = r; alu_carry = c;
    @(negedge clk);
    alu_done = 1'b0; alu_result = 4'h0; alu_carry = 1'b0;
    btn_enter = 1'b0;
    repeat (HOLD) @(negedge clk);
    chk("show.state", 8'(state), 8'd5);
    chk("show.seg", 8'(seg), 8'(hex_lut[r]));
    chk("show.ovf", 8'(ovf), 8'(c));
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    {btn_mode, btn_enter, btn_inc, btn_dec} = 4'b0000;
    alu_done = 1'b0; alu_result = 4'h0; alu_carry = 1'b0;

    //                btn          st    a     b     op    seg
    tbl[0]  = '{B_DEC,         3'd1, 4'h0, 4'h0, 1'b0, 7'b1110001};
    tbl[1]  = '{B_INC,         3'd1, 4'h0, 4'h0, 1'b0, 7'b0111111};
    tbl[2]  = '{B_INC | B_DEC, 3'd1, 4'h0, 4'h0, 1'b0, 7'b0111111};
    tbl[3]  = '{B_INC,         3'd1, 4'h0, 4'h0, 1'b0, 7'b0000110};
    tbl[4]  = '{B_INC,         3'd1, 4'h0, 4'h0, 1'b0, 7'b1011011};
    tbl[5]  = '{B_INC,         3'd1, 4'h0, 4'h0, 1'b0, 7'b1001111};
    tbl[6]  = '{B_ENTER,       3'd2, 4'h3, 4'h0, 1'b0, 7'b0111111};
    tbl[7]  = '{B_INC,         3'd2, 4'h3, 4'h0, 1'b0, 7'b0000110};
    tbl[8]  = '{B_MODE,        3'd2, 4'h3, 4'h0, 1'b1, 7'b0000110};
    tbl[9]  = '{B_MODE,        3'd2, 4'h3, 4'h0, 1'b0, 7'b0000110};
    tbl[10] = '{B_INC,         3'd2, 4'h3, 4'h0, 1'b0, 7'b1011011};
    tbl[11] = '{B_ENTER,       3'd1, 4'h5, 4'h2, 1'b0, 7'b1101101};
    tbl[12] = '{B_ENTER,       3'd2, 4'h5, 4'h2, 1'b0, 7'b0111111};
    tbl[13] = '{B_INC,         3'd2, 4'h5, 4'h2, 1'b0, 7'b0000110};
    tbl[14] = '{B_INC,         3'd2, 4'h5, 4'h2, 1'b0, 7'b1011011};
    tbl[15] = '{B_INC,         3'd2, 4'h5, 4'h2, 1'b0, 7'b1001111};
    tbl[16] = '{B_INC,         3'd2, 4'h5, 4'h2, 1'b0, 7'b1100110};
    tbl[17] = '{B_INC,         3'd2, 4'h5, 4'h2, 1'b0, 7'b1101101};
    tbl[18] = '{B_ENTER,       3'd1, 4'hA, 4'h5, 1'b0, 7'b1110111};
    tbl[19] = '{B_MODE,        3'd1, 4'hA, 4'h5, 1'b1, 7'b1110111};
    tbl[20] = '{B_ENTER,       3'd2, 4'hA, 4'h5, 1'b1, 7'b0111111};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.state", 8'(state), 8'd0);
    chk("rst.seg", 8'(seg), 8'h40);
    chk("rst.alu_a", 8'(alu_a), 8'd0);
    chk("rst.alu_b", 8'(alu_b), 8'd0);
    chk("rst.alu_op", 8'(alu_op), 8'd0);
    chk("rst.alu_start", 8'(alu_start), 8'd0);
    chk("rst.ovf", 8'(ovf), 8'd0);
    chk("rst.err", 8'(err), 8'd0);

`ifndef CALC_DEBOUNCE_EN
    // Pulse lands 3 cycles after the raw rise, so the FSM moves on the 4th edge.
    btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    chk("lat.state_before", 8'(state), 8'd0);
    @(negedge clk);
    chk("lat.state_after", 8'(state), 8'd1);
    btn_enter = 1'b0;
    repeat (HOLD) @(negedge clk);
`else
    press(B_ENTER);
    chk("enter.state", 8'(state), 8'd1);
`endif
    chk("enter.seg", 8'(seg), 8'b0111111);

    apply_range(0, 10);
    run_op(4'h5, 1'b0, 4'h3, 4'h2, 1'b0);
    apply_range(11, 17);
    run_op(4'hA, 1'b1, 4'h5, 4'h5, 1'b0);
    apply_range(18, 20);

    // Timeout: WAIT holds for T+1 cycles without completion, then ERR.
    btn_enter = 1'b1;
    wait_state(3'd4, ok);
    chk("tmo.reach_wait", 8'(ok), 8'd1);
    btn_enter = 1'b0;
    repeat (T) @(negedge clk);
    chk("tmo.still_wait", 8'(state), 8'd4);
    @(negedge clk);
    chk("tmo.state", 8'(state), 8'd6);
    chk("tmo.err", 8'(err), 8'd1);
    @(negedge clk);
    chk("tmo.seg", 8'(seg), 8'b1111001);
    alu_done = 1'b1; alu_result = 4'h3;
    @(negedge clk);
    alu_done = 1'b0; alu_result = 4'h0;
    @(negedge clk);
    chk("err.done_ignored_state", 8'(state), 8'd6);
    chk("err.done_ignored_ovf", 8'(ovf), 8'd1);
    press(B_MODE);
    chk("err.mode_ignored_state", 8'(state), 8'd6);
    chk("err.mode_ignored_op", 8'(alu_op), 8'd1);
    press(B_ENTER);
    chk("err.exit_state", 8'(state), 8'd0);
    chk("err.exit_err", 8'(err), 8'd0);
    chk("err.exit_seg", 8'(seg), 8'h40);

    // Completion on the final WAIT cycle beats the timeout.
    press(B_ENTER);
    press(B_ENTER);
    btn_enter = 1'b1;
    wait_state(3'd4, ok);
    chk("edge.reach_wait", 8'(ok), 8'd1);
    btn_enter = 1'b0;
    repeat (T) @(negedge clk);
    chk("edge.still_wait", 8'(state), 8'd4);
    alu_done = 1'b1; alu_result = 4'h7; alu_carry = 1'b0;
    @(negedge clk);
    alu_done = 1'b0; alu_result = 4'h0;
    chk("edge.state", 8'(state), 8'd5);
    @(negedge clk);
    chk("edge.seg", 8'(seg), 8'b0000111);
    chk("edge.ovf", 8'(ovf), 8'd0);

    // Reset while waiting aborts the operation; a late completion is ignored.
    press(B_ENTER);
    chk("chain7.alu_a", 8'(alu_a), 8'h7);
    press(B_ENTER);
    btn_enter = 1'b1;
    wait_state(3'd4, ok);
    chk("rstw.reach_wait", 8'(ok), 8'd1);
    btn_enter = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    alu_done = 1'b1; alu_result = 4'h9; alu_carry = 1'b1;
    @(negedge clk);
    alu_done = 1'b0; alu_result = 4'h0; alu_carry = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstw.state", 8'(state), 8'd0);
    chk("rstw.ovf", 8'(ovf), 8'd0);
    chk("rstw.seg", 8'(seg), 8'h40);
    chk("rstw.alu_a", 8'(alu_a), 8'd0);

`ifdef CALC_DEBOUNCE_EN
    press(B_ENTER);
    chk("deb.enter_state", 8'(state), 8'd1);
    btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    btn_inc = 1'b0;
    repeat (15) @(negedge clk);
    chk("deb.glitch_seg", 8'(seg), 8'b0111111);
    btn_inc = 1'b1;
    repeat (10) @(negedge clk);
    btn_inc = 1'b0;
    repeat (15) @(negedge clk);
    chk("deb.press_seg", 8'(seg), 8'b0000110);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable cycles required to accept a button level change.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum cycles spent waiting for alu_done.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn_mode, btn_enter, btn_inc, btn_dec  input  1 each  raw asynchronous push buttons, active-high.
REQ-006 alu_a, alu_b  output  4 each  operands presented to the external ALU.
REQ-007 alu_op  output  1  0 = add, 1 = subtract.
REQ-008 alu_start  output  1  single-cycle request to the ALU.
REQ-009 alu_done  input  1  single-cycle completion from the ALU.
REQ-010 alu_result  input  4  ALU result, valid when alu_done=1.
REQ-011 alu_carry  input  1  carry/borrow, valid when alu_done=1.
REQ-012 seg  output  7  seven-segment pattern, active-high, bit0=a through bit6=g.
REQ-013 ovf  output  1  latched alu_carry of the last completed operation.
REQ-014 err  output  1  high while in ERR.
REQ-015 state  output  3  current FSM state encoding.

Function
REQ-016 Each button SHALL pass a 2-flop synchronizer and rising-edge detector, producing a 1-cycle pulse per press.
REQ-017 FSM states SHALL be IDLE=0, ENTER_A=1, ENTER_B=2, EXEC=3, WAIT=4, SHOW=5, ERR=6; code 7 SHALL recover to IDLE.
REQ-018 IDLE: enter pulse -> ENTER_A with the 4-bit edit register cleared to 0.
REQ-019 ENTER_A/ENTER_B: inc pulse -> edit+1; dec pulse -> edit-1; both modulo 16 (F+1=0, 0-1=F).
REQ-020 Simultaneous inc and dec pulses in the same cycle SHALL leave the edit register unchanged.
REQ-021 Mode pulse in ENTER_A or ENTER_B SHALL toggle alu_op; in all other states it SHALL be ignored.
REQ-022 ENTER_A: enter latches edit into alu_a, clears edit, -> ENTER_B.
REQ-023 ENTER_B: enter latches edit into alu_b, -> EXEC.
REQ-024 EXEC: alu_start=1 for exactly one cycle, timeout counter cleared, -> WAIT.
REQ-025 WAIT: alu_done latches alu_result into the result register and alu_carry into ovf, -> SHOW.
REQ-026 WAIT: if alu_done is still low when the counter reaches TIMEOUT_CYCLES, -> ERR; alu_done in that same cycle takes priority.
REQ-027 alu_done outside WAIT SHALL be ignored.
REQ-028 SHOW: enter -> ENTER_A with alu_a and edit both loaded with the result, for chained operation.
REQ-029 ERR: enter -> IDLE; all other buttons ignored.
REQ-030 Button pulses SHALL be ignored in EXEC and WAIT.
REQ-031 seg SHALL be registered, updating one cycle after a state or value change: IDLE -> 7'b1000000 (dash); ENTER -> hex of edit; EXEC/WAIT -> hex of alu_b; SHOW -> hex of result; ERR -> 7'b1111001 ('E').
REQ-032 Hex encoding SHALL be standard 0-F (0=7'b0111111, 5=7'b1101101, A=7'b1110111, F=7'b1110001).

Reset
REQ-033 rst SHALL force state=IDLE, alu_a=alu_b=0, alu_op=0, alu_start=0, ovf=0, err=0, edit=0, result=0, seg=7'b1000000, and clear synchronizers, debounce counters and the timeout counter.
REQ-034 rst asserted in WAIT SHALL abort the operation; a later alu_done SHALL be ignored.

Configuration
REQ-035 Macro CALC_DEBOUNCE_EN defined: each synchronized button SHALL change its filtered level only after DEB_CYCLES consecutive cycles at the new value; edge detection SHALL use the filtered level.
REQ-036 CALC_DEBOUNCE_EN undefined: no filter; a pulse SHALL appear exactly 3 cycles after the raw button rises.

Verification
REQ-037 Macro off; enter, inc x3, enter, inc x2, enter; ALU returns 5 after 2 cycles -> alu_a=3, alu_b=2, alu_op=0, alu_start one cycle, seg=7'b1101101, state=5.
REQ-038 ENTER_A with edit=0; dec -> edit=F, seg=7'b1110001; inc -> edit=0; inc and dec in the same cycle -> edit unchanged.
REQ-039 WAIT with alu_done held low for TIMEOUT_CYCLES -> state=6, err=1, seg=7'b1111001; enter -> state=0, err=0.
REQ-040 Macro on, DEB_CYCLES=4; 3-cycle glitch on btn_inc -> no change; 10-cycle press -> exactly one increment.
REQ-041 SHOW with result=A; enter -> state=1, alu_a=A, seg=7'b1110111; mode -> alu_op toggles.
REQ-042 rst asserted in WAIT, then alu_done pulsed -> state=0, ovf=0, seg=7'b1000000, no latch.
